// File: rtl/dcache_port_arbiter_pkg.sv
// Shared constants, port tags and address helpers for the data-memory port arbiter.
package dcache_arb_pkg;

  localparam int unsigned SBOX_BASE = 128;
  localparam int unsigned RAM_WORDS = 384;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_tag_e;

  function automatic logic [8:0] word_idx(input logic [31:0] addr);
    return addr[10:2];
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Requester, memory and status signals of the data-memory port arbiter.
// The arbiter uses the slave modport; requesters and memory model use master.
interface dcache_port_arbiter_if;

  logic        in_a_req;
  logic        in_a_we;
  logic [31:0] in_a_addr;
  logic [31:0] in_a_wdata;
  logic        out_a_gnt;
  logic        out_a_rvalid;
  logic [31:0] out_a_rdata;

  logic        in_b_req;
  logic        in_b_we;
  logic [31:0] in_b_addr;
  logic [31:0] in_b_wdata;
  logic        out_b_gnt;
  logic        out_b_rvalid;
  logic [31:0] out_b_rdata;

  logic        out_mem_wr;
  logic        out_mem_rd;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_wdata;
  logic [31:0] in_mem_rdata;
  logic        out_wr_err;

  modport slave (
    input  in_a_req, in_a_we, in_a_addr, in_a_wdata,
    input  in_b_req, in_b_we, in_b_addr, in_b_wdata,
    input  in_mem_rdata,
    output out_a_gnt, out_a_rvalid, out_a_rdata,
    output out_b_gnt, out_b_rvalid, out_b_rdata,
    output out_mem_wr, out_mem_rd, out_mem_addr, out_mem_wdata, out_wr_err
  );

  modport master (
    output in_a_req, in_a_we, in_a_addr, in_a_wdata,
    output in_b_req, in_b_we, in_b_addr, in_b_wdata,
    output in_mem_rdata,
    input  out_a_gnt, out_a_rvalid, out_a_rdata,
    input  out_b_gnt, out_b_rvalid, out_b_rdata,
    input  out_mem_wr, out_mem_rd, out_mem_addr, out_mem_wdata, out_wr_err
  );

endinterface

// File: rtl/dcache_port_arbiter_age_counter.sv
// Saturating 4-bit count of cycles port B has been refused; sat forces a B grant.
module arb_age_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_inc,
  input  logic in_clr,
  output logic out_sat
);

  logic [3:0] r_cnt;
  logic       w_sat;

  assign w_sat   = (r_cnt == 4'(MAX));
  assign out_sat = w_sat;

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_cnt <= 4'd0;
    end else if (in_clr) begin
      r_cnt <= 4'd0;
    end else if (in_inc && !w_sat) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Two-port arbiter for the single-port data memory: A has priority, B is aged.
// Define WR_PROT_EN to drop writes into the S-box region and pulse out_wr_err instead.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int unsigned B_MAX_WAIT = 4
) (
  input logic                  in_clk,
  input logic                  in_rst,
  dcache_port_arbiter_if.slave bus
);

  logic        w_b_sat;
  logic        w_a_win;
  logic        w_b_win;
  logic        w_win;
  logic        w_we;
  logic        w_prot;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  logic        r_mem_wr;
  logic        r_mem_rd;
  logic        r_wr_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  port_tag_e   r_tag;
  logic        r_a_rvalid;
  logic        r_b_rvalid;
  logic [31:0] r_a_rdata;
  logic [31:0] r_b_rdata;

  // B only overrides A once it has been refused B_MAX_WAIT times in a row.
  assign w_a_win = bus.in_a_req & ~(bus.in_b_req & w_b_sat);
  assign w_b_win = bus.in_b_req & ~w_a_win;
  assign w_win   = w_a_win | w_b_win;

  always_comb begin
    w_we    = bus.in_a_we;
    w_addr  = bus.in_a_addr;
    w_wdata = bus.in_a_wdata;
    if (w_b_win) begin
      w_we    = bus.in_b_we;
      w_addr  = bus.in_b_addr;
      w_wdata = bus.in_b_wdata;
    end
  end

`ifdef WR_PROT_EN
  assign w_prot = w_we & (32'(word_idx(w_addr)) >= SBOX_BASE);
`else
  assign w_prot = 1'b0;
`endif

  arb_age_counter #(
    .MAX (B_MAX_WAIT)
  ) u_age (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .in_inc  (bus.in_b_req & ~w_b_win),
    .in_clr  (~bus.in_b_req | w_b_win),
    .out_sat (w_b_sat)
  );

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_wr_err    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_tag       <= PORT_A;
    end else begin
      r_mem_rd <= w_win & ~w_we;
      r_mem_wr <= w_win & w_we & ~w_prot;
      r_wr_err <= w_win & w_prot;
      if (w_win) begin
        r_mem_addr  <= w_addr;
        r_mem_wdata <= w_wdata;
        r_tag       <= w_b_win ? PORT_B : PORT_A;
      end
    end
  end

  // Memory read data is combinational, so capture it at the end of the access cycle.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= 32'd0;
      r_b_rdata  <= 32'd0;
    end else begin
      r_a_rvalid <= r_mem_rd & (r_tag == PORT_A);
      r_b_rvalid <= r_mem_rd & (r_tag == PORT_B);
      if (r_mem_rd && r_tag == PORT_A) r_a_rdata <= bus.in_mem_rdata;
      if (r_mem_rd && r_tag == PORT_B) r_b_rdata <= bus.in_mem_rdata;
    end
  end

  assign bus.out_a_gnt     = w_a_win;
  assign bus.out_b_gnt     = w_b_win;
  assign bus.out_a_rvalid  = r_a_rvalid;
  assign bus.out_b_rvalid  = r_b_rvalid;
  assign bus.out_a_rdata   = r_a_rdata;
  assign bus.out_b_rdata   = r_b_rdata;
  assign bus.out_mem_wr    = r_mem_wr;
  assign bus.out_mem_rd    = r_mem_rd;
  assign bus.out_mem_addr  = r_mem_addr;
  assign bus.out_mem_wdata = r_mem_wdata;
  assign bus.out_wr_err    = r_wr_err;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: directed cases plus random traffic vs a reference model.
module tb_dcache_port_arbiter;

  localparam int unsigned BMaxWait = 4;
`ifdef WR_PROT_EN
  localparam bit ProtEn = 1'b1;
`else
  localparam bit ProtEn = 1'b0;
`endif

  typedef struct {
    bit          rd;
    bit          wr;
    bit          err;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic clk;
  logic rst;
  dcache_port_arbiter_if bus ();

  dcache_port_arbiter #(
    .B_MAX_WAIT (BMaxWait)
  ) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int a_rv_all = 0;
  bit chk_en   = 1'b0;
  int b_wait   = 0;

  logic [31:0] ram     [0:383];
  logic [31:0] ref_mem [0:383];
  cmd_t        cmd_q[$];
  logic [31:0] a_q[$];
  logic [31:0] b_q[$];
  logic [31:0] a_log[$];
  int          a_cyc[$];

  function automatic logic [31:0] ram_init(input int i);
    case (i)
      4:       return 32'h3243f6a8;
      5:       return 32'h885a308d;
      6:       return 32'h313198a2;
      7:       return 32'he0370734;
      128:     return 32'h00000063;
      129:     return 32'h0000007c;
      default: return 32'(i) * 32'h9e3779b9;
    endcase
  endfunction

  // Memory model: combinational read, write at the clock edge ending the access cycle.
  logic [8:0] mem_idx;
  assign mem_idx          = bus.out_mem_addr[10:2];
  assign bus.in_mem_rdata = (mem_idx < 9'd384) ? ram[mem_idx] : 32'd0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 384; i++) ram[i] <= ram_init(i);
    end else if (bus.out_mem_wr && mem_idx < 9'd384) begin
      ram[mem_idx] <= bus.out_mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (bus.out_a_rvalid) a_rv_all++;

  // Monitor: pops expectations whenever the DUT presents a command or a response.
  always @(negedge clk) begin
    if (chk_en) begin
      if (cmd_q.size() == 0) begin
        check("cmd_queue_nonempty", 32'd0, 32'd1);
      end else begin
        cmd_t e;
        e = cmd_q.pop_front();
        check("mem_rd_wr_err", {29'd0, bus.out_mem_rd, bus.out_mem_wr, bus.out_wr_err},
              {29'd0, e.rd, e.wr, e.err});
        if (e.rd || e.we) check("mem_addr", bus.out_mem_addr, e.addr);
        if (e.we) check("mem_wdata", bus.out_mem_wdata, e.wdata);
      end
      if (bus.out_a_rvalid) begin
        a_log.push_back(bus.out_a_rdata);
        a_cyc.push_back(cyc);
        if (a_q.size() == 0) check("a_rvalid_expected", 32'd1, 32'd0);
        else check("a_rdata", bus.out_a_rdata, a_q.pop_front());
      end
      if (bus.out_b_rvalid) begin
        if (b_q.size() == 0) check("b_rvalid_expected", 32'd1, 32'd0);
        else check("b_rdata", bus.out_b_rdata, b_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r       = $urandom();
    r[10:2] = 9'($urandom_range(383));
    return r;
  endfunction

  // Called just after a rising edge; returns just after the next one.
  task automatic drive(input bit a_req, input bit a_we, input logic [31:0] a_addr,
                       input logic [31:0] a_wdata, input bit b_req, input bit b_we,
                       input logic [31:0] b_addr, input logic [31:0] b_wdata,
                       output bit a_won, output bit b_won, output bit b_gnt_obs);
    cmd_t e;
    int   idx;
    bus.in_a_req   = a_req;
    bus.in_a_we    = a_we;
    bus.in_a_addr  = a_addr;
    bus.in_a_wdata = a_wdata;
    bus.in_b_req   = b_req;
    bus.in_b_we    = b_we;
    bus.in_b_addr  = b_addr;
    bus.in_b_wdata = b_wdata;
    @(negedge clk);
    a_won = a_req && !(b_req && b_wait >= int'(BMaxWait));
    b_won = b_req && !a_won;
    b_gnt_obs = bus.out_b_gnt;
    check("a_gnt", {31'd0, bus.out_a_gnt}, {31'd0, a_won});
    check("b_gnt", {31'd0, bus.out_b_gnt}, {31'd0, b_won});
    if (b_req && !b_won) b_wait = (b_wait < int'(BMaxWait)) ? b_wait + 1 : b_wait;
    else b_wait = 0;
    e = '{rd: 0, wr: 0, err: 0, we: 0, addr: 32'd0, wdata: 32'd0};
    if (a_won || b_won) begin
      e.we    = a_won ? a_we : b_we;
      e.addr  = a_won ? a_addr : b_addr;
      e.wdata = a_won ? a_wdata : b_wdata;
      idx     = int'(e.addr[10:2]);
      if (!e.we) begin
        e.rd = 1;
        if (a_won) a_q.push_back(ref_mem[idx]);
        else b_q.push_back(ref_mem[idx]);
      end else if (ProtEn && idx >= 128) begin
        e.err = 1;
      end else begin
        e.wr = 1;
        ref_mem[idx] = e.wdata;
      end
    end
    cmd_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit x0, x1, x2;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, x0, x1, x2);
  endtask

  task automatic reset_dut();
    cmd_t e;
    chk_en         = 1'b0;
    rst            = 1'b1;
    bus.in_a_req   = 0;
    bus.in_a_we    = 0;
    bus.in_a_addr  = 0;
    bus.in_a_wdata = 0;
    bus.in_b_req   = 0;
    bus.in_b_we    = 0;
    bus.in_b_addr  = 0;
    bus.in_b_wdata = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmd_q.delete();
    a_q.delete();
    b_q.delete();
    b_wait = 0;
    for (int i = 0; i < 384; i++) ref_mem[i] = ram_init(i);
    e = '{rd: 0, wr: 0, err: 0, we: 0, addr: 32'd0, wdata: 32'd0};
    cmd_q.push_back(e);
    chk_en = 1'b1;
  endtask

  initial begin
    bit          aw, bw, bg;
    bit          a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [9:0]  pattern;
    int          rv_before;

    rst = 1'b1;
    @(posedge clk);
    #1;
    reset_dut();

    // Reset state.
    check("reset_outputs_zero",
          {31'd0, |{bus.out_a_gnt, bus.out_a_rvalid, bus.out_a_rdata, bus.out_b_gnt,
                    bus.out_b_rvalid, bus.out_b_rdata, bus.out_mem_wr, bus.out_mem_rd,
                    bus.out_mem_addr, bus.out_mem_wdata, bus.out_wr_err}}, 32'd0);

    // Reset one cycle after an A read grant discards the read.
    drive(1, 0, 32'h200, 0, 0, 0, 0, 0, aw, bw, bg);
    rv_before = a_rv_all;
    reset_dut();
    idle(4);
    check("no_rvalid_after_reset", 32'(a_rv_all), 32'(rv_before));

    // Single A read of the first S-box word.
    drive(1, 0, 32'h200, 0, 0, 0, 0, 0, aw, bw, bg);
    idle(1);
    check("a_rvalid_t2", {31'd0, bus.out_a_rvalid}, 32'd1);
    check("a_read_sbox0", bus.out_a_rdata, 32'h00000063);

    // A write then B read of the same word on consecutive grants.
    drive(1, 1, 32'h20, 32'h11223344, 0, 0, 0, 0, aw, bw, bg);
    drive(0, 0, 0, 0, 1, 0, 32'h20, 0, aw, bw, bg);
    idle(1);
    check("b_raw_data", bus.out_b_rdata, 32'h11223344);
    idle(1);

    // Continuous contention: AAAAB repeating.
    pattern = '0;
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, rand_addr(), 0, 1, 0, rand_addr(), 0, aw, bw, bg);
      pattern[i] = bg;
    end
    check("aaaab_pattern", {22'd0, pattern}, 32'h210);
    idle(3);

    // Back-to-back A reads of words 4..7.
    a_log.delete();
    a_cyc.delete();
    for (int w = 4; w < 8; w++) drive(1, 0, 32'(w * 4), 0, 0, 0, 0, 0, aw, bw, bg);
    idle(2);
    check("b2b_count", 32'(a_log.size()), 32'd4);
    if (a_log.size() == 4) begin
      check("b2b_w4", a_log[0], 32'h3243f6a8);
      check("b2b_w5", a_log[1], 32'h885a308d);
      check("b2b_w6", a_log[2], 32'h313198a2);
      check("b2b_w7", a_log[3], 32'he0370734);
      check("b2b_consecutive", 32'(a_cyc[3] - a_cyc[0]), 32'd3);
    end

    // Write into the S-box region, then read it back.
    drive(1, 1, 32'h204, 32'h0000dead, 0, 0, 0, 0, aw, bw, bg);
    idle(1);
    drive(1, 0, 32'h204, 0, 0, 0, 0, 0, aw, bw, bg);
    idle(1);
    check("sbox_write_read", bus.out_a_rdata, ProtEn ? 32'h0000007c : 32'h0000dead);
    idle(1);

    // Random traffic; a refused requester holds its command.
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
    aw = 1; bw = 1;
    for (int i = 0; i < 400; i++) begin
      if (!a_req || aw) begin
        a_req = ($urandom_range(99) < 70);
        a_we = $urandom_range(1);
        a_addr = rand_addr();
        a_wdata = $urandom();
      end
      if (!b_req || bw) begin
        b_req = ($urandom_range(99) < 60);
        b_we = $urandom_range(1);
        b_addr = rand_addr();
        b_wdata = $urandom();
      end
      drive(a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, aw, bw, bg);
    end
    idle(4);
    check("a_queue_drained", 32'(a_q.size()), 32'd0);
    check("b_queue_drained", 32'(b_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
